ofm_stream_buffer: RTL and testbench

- Synthesizable, parametrised output-feature-map buffer. Replaces simulation-only file dumping with an on-chip ping-pong store plus a streaming drain port.
- The compute datapath writes results into one layer bank by address.
- A `done` pulse freezes that bank and streams its full contents out in address order over a valid/ready interface.
- Meanwhile the other bank stays writable for the next layer.

---
 rtl/ofm_stream_buffer_if.sv | 33 +++
 rtl/ofm_stream_buffer.sv | 154 +++++++++++++++
 tb/tb_ofm_stream_buffer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofm_stream_buffer_if.sv
// Write port and drain stream of the output-feature-map buffer.
// The producer/consumer side uses master and the buffer uses slave.
interface ofm_stream_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BANK_W = 1
);
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] in;
    logic [BANK_W-1:0] wbank;
    logic              done;
    logic [BANK_W-1:0] dbank;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_adr;
    logic              out_last;
    logic              busy;
    logic              drain_done;
    logic              wr_err;

    modport master (
        output we, adr, in, wbank, done, dbank, out_ready,
        input  out_valid, out_data, out_adr, out_last, busy, drain_done, wr_err
    );

    modport slave (
        input  we, adr, in, wbank, done, dbank, out_ready,
        output out_valid, out_data, out_adr, out_last, busy, drain_done, wr_err
    );
endinterface

// File: rtl/ofm_stream_buffer.sv
// Banked output-feature-map store: the datapath fills one bank by address while a
// completed bank is streamed out in address order over valid/ready.
module ofm_stream_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 512,
    parameter int ADDR_W    = 32,
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    ofm_stream_buffer_if.slave bus
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W:0]   BANKS_X  = (BANK_W + 1)'(NUM_BANKS);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        FINISH
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem [NUM_BANKS][DEPTH];

    // The RAM output register doubles as the stream's output stage: it only
    // advances on a handshake, so stalls hold it and ready=1 gives no bubbles.
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_adr;
    logic              rd_valid;
    logic [BANK_W-1:0] drain_bank;
    logic              wr_err_q;

    logic              busy;
    logic              drain_done;
    logic              start;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic              hs;
    logic              at_last;
    logic              dbank_ok;
    logic              wbank_ok;
    logic              wr_hit_drain;
    logic              wr_ok;

    assign hs      = rd_valid && bus.out_ready;
    assign at_last = (rd_adr == LAST_ADR);

    // Zero-extended so the range test stays meaningful when NUM_BANKS fills BANK_W.
    assign dbank_ok = ({1'b0, bus.dbank} < BANKS_X);
    assign wbank_ok = ({1'b0, bus.wbank} < BANKS_X);

    assign wr_hit_drain = busy && (bus.wbank == drain_bank);
    assign wr_ok        = bus.we && (bus.adr < DEPTH_A) && wbank_ok && !wr_hit_drain;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        next_state = state;
        busy       = 1'b0;
        drain_done = 1'b0;
        start      = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = '0;

        unique case (state)
            IDLE: begin
                if (bus.done && dbank_ok) begin
                    start      = 1'b1;
                    next_state = PRIME;
                end
            end
            PRIME: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                next_state = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (hs) begin
                    if (at_last) begin
                        next_state = FINISH;
                    end else begin
                        rd_en  = 1'b1;
                        rd_idx = rd_adr[IDX_W-1:0] + IDX_W'(1);
                    end
                end
            end
            FINISH: begin
                drain_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_adr     <= '0;
            drain_bank <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            if (start)
                drain_bank <= bus.dbank;

            if (bus.we && !wr_ok)
                wr_err_q <= 1'b1;

            if (state == PRIME) begin
                rd_valid <= 1'b1;
                rd_adr   <= '0;
            end else if (state == STREAM && hs) begin
                if (at_last)
                    rd_valid <= 1'b0;
                else
                    rd_adr <= rd_adr + ADDR_W'(1);
            end
        end
    end

    // NOTE: the storage array and its read register carry no reset; contents
    // survive rst, and a reset loop over a RAM would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[bus.wbank][bus.adr[IDX_W-1:0]] <= bus.in;
        if (rd_en)
            rd_data <= mem[drain_bank][rd_idx];
    end

    assign bus.out_valid  = rd_valid;
    assign bus.out_data   = rd_data;
    assign bus.out_adr    = rd_adr;
    assign bus.out_last   = rd_valid && at_last;
    assign bus.busy       = busy;
    assign bus.drain_done = drain_done;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_ofm_stream_buffer.sv
// Directed bench for ofm_stream_buffer: fills banks, drains them under several
// ready/reset/done patterns and compares against hand-derived expectations.
module tb_ofm_stream_buffer;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 512;
    localparam int ADDR_W    = 32;
    localparam int NUM_BANKS = 2;
    localparam int BANK_W    = 1;
    localparam int CAP_MAX   = DEPTH + 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ofm_stream_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

    ofm_stream_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_BANKS(NUM_BANKS),
        .BANK_W   (BANK_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_mem [NUM_BANKS][DEPTH];

    // Observations of the last drain.
    logic [31:0] cap_data [CAP_MAX];
    logic [31:0] cap_adr  [CAP_MAX];
    int cap_n, last_cnt, last_idx, last_cyc, first_valid, busy0;
    int dd_cnt, dd_cyc, stab_err, stall_cnt, extra, timed_out;
    int rst_valid, rst_busy;

    task automatic idle_inputs();
        bus.we        = 1'b0;
        bus.adr       = '0;
        bus.in        = '0;
        bus.wbank     = '0;
        bus.done      = 1'b0;
        bus.dbank     = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_bank0();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bus.we    = 1'b1;
            bus.wbank = 1'b0;
            bus.adr   = 32'(i);
            bus.in    = 32'(i * 3 + 1);
            exp_mem[0][i] = 32'(i * 3 + 1);
        end
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    function automatic int stream_bad(input int b);
        int n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (i >= cap_n || cap_data[i] !== exp_mem[b][i] || cap_adr[i] !== 32'(i))
                n++;
        return n;
    endfunction

    // Pulses done for `bank` and records everything the stream does. Cycle 0 is
    // the negedge right after the edge that samples done.
    task automatic run_drain(input int bank, input bit rnd_ready, input int done_mid,
                             input bit done_fin, input int rst_at, input bit wr_bank1,
                             input int max_cyc);
        int          cyc = 0;
        int          wr_i = 0;
        int          post_left = 0;
        int          end_cyc = 0;
        bit          ended = 0;
        bit          rdy;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic [31:0] prev_adr = '0;
        logic        prev_last = 1'b0;

        cap_n = 0; last_cnt = 0; last_idx = -1; last_cyc = -1; first_valid = -1;
        busy0 = -1; dd_cnt = 0; dd_cyc = -1; stab_err = 0; stall_cnt = 0;
        extra = 0; timed_out = 0; rst_valid = -1; rst_busy = -1;

        bus.dbank = BANK_W'(bank);
        bus.done  = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;

        while (1) begin
            if (cyc >= max_cyc) begin
                timed_out = 1;
                break;
            end
            if (cyc == 0)
                busy0 = int'(bus.busy);
            if (cyc == rst_at + 1) begin
                rst_valid = int'(bus.out_valid);
                rst_busy  = int'(bus.busy);
            end
            if (bus.out_valid === 1'b1 && first_valid < 0)
                first_valid = cyc;
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
                               bus.out_adr !== prev_adr || bus.out_last !== prev_last))
                stab_err++;
            if (bus.drain_done === 1'b1) begin
                dd_cnt++;
                dd_cyc = cyc;
            end
            if (ended && cyc > end_cyc && (bus.busy !== 1'b0 || bus.out_valid !== 1'b0))
                extra++;

            rdy           = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            rst           = (cyc == rst_at);
            bus.done      = (cyc == done_mid) || (done_fin && bus.drain_done === 1'b1);

            if (bus.out_valid === 1'b1 && rdy && cyc != rst_at && cap_n < CAP_MAX) begin
                cap_data[cap_n] = bus.out_data;
                cap_adr[cap_n]  = bus.out_adr;
                if (bus.out_last === 1'b1) begin
                    last_cnt++;
                    last_idx = cap_n;
                    last_cyc = cyc;
                end
                cap_n++;
            end
            if (bus.out_valid === 1'b1 && !rdy)
                stall_cnt++;
            prev_stall = (bus.out_valid === 1'b1) && !rdy;
            prev_data  = bus.out_data;
            prev_adr   = bus.out_adr;
            prev_last  = bus.out_last;

            bus.we = 1'b0;
            if (wr_bank1) begin
                if (cyc == 50) begin
                    bus.we    = 1'b1;
                    bus.wbank = 1'b0;
                    bus.adr   = 32'd5;
                    bus.in    = 32'hDEAD;
                end else if (wr_i < DEPTH) begin
                    bus.we    = 1'b1;
                    bus.wbank = 1'b1;
                    bus.adr   = 32'(wr_i);
                    bus.in    = 32'hA5A5_0000 + 32'(wr_i);
                    exp_mem[1][wr_i] = 32'hA5A5_0000 + 32'(wr_i);
                    wr_i++;
                end
            end

            if (!ended && (bus.drain_done === 1'b1 || cyc == rst_at)) begin
                ended     = 1;
                end_cyc   = cyc;
                post_left = 8;
            end else if (ended && post_left > 0) begin
                post_left--;
            end
            if (ended && post_left == 0 && (!wr_bank1 || wr_i >= DEPTH))
                break;

            @(negedge clk);
            cyc++;
        end

        idle_inputs();
        rst = 1'b0;
        if (timed_out != 0)
            $display("FAIL drain_timeout: bank %0d no end after %0d cycles", bank, max_cyc);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", bus.out_last); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.drain_done !== 1'b0) $display("FAIL rst_drain_done: got %b want 0", bus.drain_done); else passed++;
        checks++; if (bus.wr_err !== 1'b0) $display("FAIL rst_wr_err: got %b want 0", bus.wr_err); else passed++;
        checks++; if (bus.out_adr !== 32'd0) $display("FAIL rst_out_adr: got %0h want 0", bus.out_adr); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_full_drain();
        int bad;
        fill_bank0();
        checks++; if (bus.wr_err !== 1'b0) $display("FAIL fill_wr_err: got %b want 0", bus.wr_err); else passed++;
        run_drain(0, 1'b0, -1, 1'b0, -1, 1'b0, 2000);
        bad = stream_bad(0);
        checks++; if (busy0 !== 1) $display("FAIL full_busy_rise: got %0d want 1", busy0); else passed++;
        checks++; if (first_valid !== 1) $display("FAIL full_first_valid_cycle: got %0d want 1", first_valid); else passed++;
        checks++; if (cap_n !== DEPTH) $display("FAIL full_word_count: got %0d want %0d", cap_n, DEPTH); else passed++;
        checks++; if (bad !== 0) $display("FAIL full_stream_data: %0d bad words want 0", bad); else passed++;
        checks++; if (cap_data[DEPTH-1] !== 32'h5FE) $display("FAIL full_last_data: got %0h want 5fe", cap_data[DEPTH-1]); else passed++;
        checks++; if (last_cnt !== 1 || last_idx !== DEPTH - 1) $display("FAIL full_out_last: count %0d at %0d want 1 at 511", last_cnt, last_idx); else passed++;
        checks++; if (last_cyc !== DEPTH) $display("FAIL full_last_cycle: got %0d want %0d", last_cyc, DEPTH); else passed++;
        checks++; if (dd_cnt !== 1 || dd_cyc !== DEPTH + 1) $display("FAIL full_drain_done: count %0d at %0d want 1 at 513", dd_cnt, dd_cyc); else passed++;
        checks++; if (extra !== 0) $display("FAIL full_busy_after: %0d active cycles want 0", extra); else passed++;
    endtask

    task automatic test_stall_drain();
        int bad;
        run_drain(0, 1'b1, -1, 1'b0, -1, 1'b0, 4000);
        bad = stream_bad(0);
        checks++; if (cap_n !== DEPTH) $display("FAIL stall_word_count: got %0d want %0d", cap_n, DEPTH); else passed++;
        checks++; if (bad !== 0) $display("FAIL stall_stream_data: %0d bad words want 0", bad); else passed++;
        checks++; if (stab_err !== 0) $display("FAIL stall_hold_stable: %0d changes want 0", stab_err); else passed++;
        checks++; if (stall_cnt <= 0) $display("FAIL stall_occurred: got %0d want >0", stall_cnt); else passed++;
        checks++; if (last_idx !== DEPTH - 1) $display("FAIL stall_out_last: got %0d want 511", last_idx); else passed++;
        checks++; if (dd_cnt !== 1) $display("FAIL stall_drain_done: got %0d want 1", dd_cnt); else passed++;
    endtask

    task automatic test_write_during_drain();
        int bad;
        run_drain(0, 1'b0, -1, 1'b0, -1, 1'b1, 3000);
        bad = stream_bad(0);
        checks++; if (bad !== 0) $display("FAIL wdd_bank0_stream: %0d bad words want 0", bad); else passed++;
        checks++; if (cap_data[5] !== 32'h10) $display("FAIL wdd_adr5: got %0h want 10", cap_data[5]); else passed++;
        checks++; if (bus.wr_err !== 1'b1) $display("FAIL wdd_wr_err: got %b want 1", bus.wr_err); else passed++;
        checks++; if (dd_cnt !== 1) $display("FAIL wdd_drain_done: got %0d want 1", dd_cnt); else passed++;
        run_drain(1, 1'b0, -1, 1'b0, -1, 1'b0, 2000);
        bad = stream_bad(1);
        checks++; if (bad !== 0) $display("FAIL wdd_bank1_stream: %0d bad words want 0", bad); else passed++;
        checks++; if (cap_data[0] !== 32'hA5A5_0000) $display("FAIL wdd_bank1_first: got %0h want a5a50000", cap_data[0]); else passed++;
        checks++; if (cap_data[DEPTH-1] !== 32'hA5A5_01FF) $display("FAIL wdd_bank1_last: got %0h want a5a501ff", cap_data[DEPTH-1]); else passed++;
    endtask

    task automatic test_reset_mid_drain();
        int bad;
        // Word 100 is presented at cycle 101 with ready held high.
        run_drain(0, 1'b0, -1, 1'b0, 101, 1'b0, 1000);
        checks++; if (rst_valid !== 0) $display("FAIL rmd_out_valid: got %0d want 0", rst_valid); else passed++;
        checks++; if (rst_busy !== 0) $display("FAIL rmd_busy: got %0d want 0", rst_busy); else passed++;
        checks++; if (dd_cnt !== 0) $display("FAIL rmd_no_drain_done: got %0d want 0", dd_cnt); else passed++;
        checks++; if (cap_n !== 100) $display("FAIL rmd_words_before_rst: got %0d want 100", cap_n); else passed++;
        checks++; if (extra !== 0) $display("FAIL rmd_quiet_after: %0d active cycles want 0", extra); else passed++;
        checks++; if (bus.wr_err !== 1'b0) $display("FAIL rmd_wr_err_cleared: got %b want 0", bus.wr_err); else passed++;
        run_drain(0, 1'b0, -1, 1'b0, -1, 1'b0, 2000);
        bad = stream_bad(0);
        checks++; if (first_valid !== 1) $display("FAIL rmd_redrain_first_valid: got %0d want 1", first_valid); else passed++;
        checks++; if (cap_n !== DEPTH || bad !== 0) $display("FAIL rmd_redrain_stream: %0d words %0d bad want 512/0", cap_n, bad); else passed++;
    endtask

    task automatic test_out_of_range();
        int bad;
        checks++; if (bus.wr_err !== 1'b0) $display("FAIL oor_wr_err_before: got %b want 0", bus.wr_err); else passed++;
        @(negedge clk);
        bus.we = 1'b1; bus.wbank = 1'b0; bus.adr = 32'd512; bus.in = 32'hBAD0_0001;
        @(negedge clk);
        bus.adr = 32'hFFFF_FFFF; bus.in = 32'hBAD0_0002;
        @(negedge clk);
        bus.we = 1'b0;
        checks++; if (bus.wr_err !== 1'b1) $display("FAIL oor_wr_err_set: got %b want 1", bus.wr_err); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (bus.wr_err !== 1'b1) $display("FAIL oor_wr_err_sticky: got %b want 1", bus.wr_err); else passed++;
        run_drain(0, 1'b0, -1, 1'b0, -1, 1'b0, 2000);
        bad = stream_bad(0);
        checks++; if (bad !== 0) $display("FAIL oor_mem_unchanged: %0d bad words want 0", bad); else passed++;
        checks++; if (cap_data[0] !== 32'h1 || cap_data[DEPTH-1] !== 32'h5FE) $display("FAIL oor_edge_words: got %0h/%0h want 1/5fe", cap_data[0], cap_data[DEPTH-1]); else passed++;
        checks++; if (bus.wr_err !== 1'b1) $display("FAIL oor_wr_err_after_drain: got %b want 1", bus.wr_err); else passed++;
        pulse_rst();
        checks++; if (bus.wr_err !== 1'b0) $display("FAIL oor_wr_err_rst: got %b want 0", bus.wr_err); else passed++;
    endtask

    task automatic test_done_ignored();
        int bad;
        run_drain(0, 1'b0, 200, 1'b1, -1, 1'b0, 2000);
        bad = stream_bad(0);
        checks++; if (cap_n !== DEPTH || bad !== 0) $display("FAIL dig_stream: %0d words %0d bad want 512/0", cap_n, bad); else passed++;
        checks++; if (last_cyc !== DEPTH) $display("FAIL dig_last_cycle: got %0d want %0d", last_cyc, DEPTH); else passed++;
        checks++; if (dd_cnt !== 1) $display("FAIL dig_drain_done_count: got %0d want 1", dd_cnt); else passed++;
        checks++; if (extra !== 0) $display("FAIL dig_no_restart: %0d active cycles want 0", extra); else passed++;
    endtask

    initial begin
        test_reset();
        test_full_drain();
        test_stall_drain();
        test_write_during_drain();
        test_reset_mid_drain();
        test_out_of_range();
        test_done_ignored();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
